// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader.
//   state_t        : top-level sequencing FSM states
//   RAM_RD_LATENCY : registered read latency of the 1Kx36 block RAM, in cycles
//   SKID_DEPTH     : entries in the output skid FIFO (also the issue credit limit)
package ram_stream_reader_pkg;

    localparam int RAM_RD_LATENCY = 2;
    localparam int SKID_DEPTH     = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/ram_stream_skid_fifo.sv
// Small synchronous FIFO that catches RAM read data already in flight when the
// downstream consumer stalls.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en_i      : push wr_data_i
//   wr_data_i    : data to push
//   rd_en_i      : pop the head entry
//   rd_data_o    : head entry (zero after reset)
//   count_o      : number of valid entries, 0..DEPTH
module ram_stream_skid_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_rd;
    logic             do_wr;

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign do_rd = rd_en_i && (count_q != '0);
    assign do_wr = wr_en_i && ((count_q != (AW+1)'(DEPTH)) || do_rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams num_words words from the block RAM, starting at start_addr and
// wrapping modulo depth_len, onto a valid/ready interface. Reads are issued
// only while the skid FIFO has room for them plus every read still in the RAM
// pipeline, so backpressure never loses data.
//   clk, reset_n         : RAM read clock, asynchronous active-low reset
//   start, start_addr,
//   num_words            : transfer request (start ignored while busy)
//   busy, done           : transfer in progress, one-cycle completion pulse
//   ram_en, ram_addr     : RAM read port control
//   ram_do               : RAM read data (two-cycle registered latency)
//   dout, dout_valid,
//   dout_ready           : output stream
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int depth_len  = 1024,
    parameter int depth_bits = 10,
    parameter int width_bits = 36
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [depth_bits-1:0] start_addr,
    input  logic [depth_bits:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [depth_bits-1:0] ram_addr,
    input  logic [width_bits-1:0] ram_do,
    output logic [width_bits-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int CW = $clog2(SKID_DEPTH) + 1;

    state_t                    state_q, state_d;
    logic [depth_bits-1:0]     addr_q, addr_d;
    logic [depth_bits:0]       issue_left_q, issue_left_d;
    logic [depth_bits:0]       out_left_q, out_left_d;
    logic [RAM_RD_LATENCY-1:0] vld_q, vld_d;
    logic                      len_zero_q, len_zero_d;

    logic [CW-1:0]             fifo_count;
    logic [CW-1:0]             inflight;
    logic [CW:0]               credit_used;
    logic                      issue;
    logic                      handshake;

    ram_stream_skid_fifo #(
        .WIDTH (width_bits),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (vld_q[RAM_RD_LATENCY-1]),
        .wr_data_i (ram_do),
        .rd_en_i   (handshake),
        .rd_data_o (dout),
        .count_o   (fifo_count)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_RD_LATENCY; i++) begin
            inflight = inflight + CW'(vld_q[i]);
        end
    end

    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue       = (state_q == ISSUE) && (issue_left_q != '0)
                         && (credit_used < (CW+1)'(SKID_DEPTH));
    assign dout_valid  = (fifo_count != '0);
    assign handshake   = dout_valid && dout_ready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        len_zero_d   = len_zero_q;
        // vld_q[0] tags the address presented this cycle; the top bit lines
        // up with the cycle its data appears on ram_do.
        vld_d        = {vld_q[RAM_RD_LATENCY-2:0], issue};

        if (handshake) begin
            out_left_d = out_left_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        len_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        len_zero_d   = 1'b0;
                        addr_d       = start_addr;
                        issue_left_d = num_words;
                        out_left_d   = num_words;
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d       = (addr_q == depth_bits'(depth_len - 1))
                                   ? '0 : addr_q + 1'b1;
                    issue_left_d = issue_left_q - 1'b1;
                    if (issue_left_q == (depth_bits+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The final handshake empties both the FIFO and the pipeline.
                if (handshake && (out_left_q == (depth_bits+1)'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                len_zero_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            vld_q        <= '0;
            len_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            vld_q        <= vld_d;
            len_zero_q   <= len_zero_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    // A zero-length request passes through DONE without touching the RAM.
    assign ram_en   = busy && !len_zero_q;
    assign ram_addr = addr_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

    localparam int DL = 1024;
    localparam int DB = 10;
    localparam int WB = 36;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DB-1:0] start_addr = '0;
    logic [DB:0]   num_words = '0;
    logic          busy, done, ram_en;
    logic [DB-1:0] ram_addr;
    logic [WB-1:0] ram_do = '0;
    logic [WB-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [WB-1:0] sb_q [$];
    int hs_count = 0;
    int hs_base = 0;
    int first_hs_edge = 0;
    int last_hs_edge = 0;

    ram_stream_reader #(
        .depth_len  (DL),
        .depth_bits (DB),
        .width_bits (WB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_do     (ram_do),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Block RAM model: registered address, then registered data output.
    logic [WB-1:0] mem [DL];
    logic [DB-1:0] ram_addr_r = '0;
    initial for (int i = 0; i < DL; i++) mem[i] = WB'(i);
    always @(posedge clk) begin
        if (ram_en) begin
            ram_addr_r <= ram_addr;
            ram_do     <= mem[ram_addr_r];
        end
    end

    // Monitor: the handshake happens on the next rising edge.
    always @(negedge clk) begin
        logic [WB-1:0] exp_w;
        if (reset_n && dout_valid && dout_ready) begin
            if (hs_count == hs_base) first_hs_edge = cyc + 1;
            last_hs_edge = cyc + 1;
            hs_count++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL stream_extra got=%0d expected=none", dout);
            end else begin
                exp_w = sb_q.pop_front();
                if (dout !== exp_w) begin
                    bad++;
                    $display("FAIL stream_data got=%0d expected=%0d", dout, exp_w);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int addr, input int n);
        start_addr = DB'(addr);
        num_words  = (DB+1)'(n);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic push_expected(input int addr, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(WB'((addr + i) % DL));
    endtask

    task automatic wait_done(input int budget, output int seen);
        bit hit = 0;
        seen = -1;
        for (int i = 0; i < budget && !hit; i++) begin
            if (done) begin
                hit  = 1;
                seen = cyc;
            end else begin
                tick();
            end
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=none expected=done within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_ram_en"},     ram_en,     0);
        check({tag, "_ram_addr"},   ram_addr,   0);
        check({tag, "_dout"},       dout,       0);
        check({tag, "_dout_valid"}, dout_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int extra;
        logic [7:0] pat;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Basic read
        dout_ready = 1'b1;
        hs_base = hs_count;
        push_expected(5, 8);
        pulse_start(5, 8);
        check("basic_addr0", ram_addr, 5);
        check("basic_ram_en", ram_en, 1);
        check("basic_busy", busy, 1);
        tick();
        tick();
        check("basic_valid_early", dout_valid, 0);
        tick();
        check("basic_valid_lat3", dout_valid, 1);
        wait_done(50, dc);
        check("basic_done_timing", dc, last_hs_edge);
        check("basic_no_bubbles", last_hs_edge - first_hs_edge, 7);
        check("basic_count", hs_count - hs_base, 8);
        check("basic_sb_empty", sb_q.size(), 0);
        tick();
        check("basic_done_pulse", done, 0);
        check("basic_busy_fall", busy, 0);

        // Wrap-around
        hs_base = hs_count;
        push_expected(1020, 8);
        pulse_start(1020, 8);
        wait_done(50, dc);
        check("wrap_count", hs_count - hs_base, 8);
        check("wrap_sb_empty", sb_q.size(), 0);
        tick();

        // Backpressure
        dout_ready = 1'b0;
        hs_base = hs_count;
        push_expected(200, 16);
        pulse_start(200, 16);
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            dout_ready = pat[i];
            tick();
        end
        dout_ready = 1'b0;
        repeat (6) tick();
        check("bp_stall_addr", ram_addr, 200 + (hs_count - hs_base) + 4);
        check("bp_valid_held", dout_valid, 1);
        repeat (14) tick();
        check("bp_stall_hold", ram_addr, 200 + (hs_count - hs_base) + 4);
        dout_ready = 1'b1;
        wait_done(100, dc);
        check("bp_count", hs_count - hs_base, 16);
        check("bp_sb_empty", sb_q.size(), 0);
        tick();

        // Zero length
        hs_base = hs_count;
        pulse_start(7, 0);
        check("zero_done", done, 1);
        check("zero_ram_en", ram_en, 0);
        check("zero_valid", dout_valid, 0);
        tick();
        check("zero_done_fall", done, 0);
        check("zero_busy_fall", busy, 0);
        check("zero_ram_en_after", ram_en, 0);
        check("zero_no_words", hs_count - hs_base, 0);
        tick();

        // Full depth with an ignored second start
        hs_base = hs_count;
        push_expected(0, 1024);
        pulse_start(0, 1024);
        repeat (100) tick();
        pulse_start(500, 3);
        wait_done(1500, dc);
        check("full_done_timing", dc, last_hs_edge);
        check("full_count", hs_count - hs_base, 1024);
        check("full_sb_empty", sb_q.size(), 0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) extra++;
        end
        check("full_single_done", extra, 0);
        check("full_idle", busy, 0);

        // Reset during DRAIN
        dout_ready = 1'b0;
        push_expected(10, 4);
        pulse_start(10, 4);
        repeat (6) tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        dout_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        hs_base = hs_count;
        push_expected(100, 4);
        pulse_start(100, 4);
        wait_done(50, dc);
        check("postrst_count", hs_count - hs_base, 4);
        check("postrst_sb_empty", sb_q.size(), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
